// File: rtl/inst_fetch.sv
// Program-counter / fetch-control stage feeding the instruction ROM.
// Ports:
//   Clk, Reset (sync, active-low)       clock and reset
//   Start                               begin a run from IDLE or HALTED
//   Stall                               hold PC this cycle
//   BranchEn, BranchRel, TargetSel      branch request through the target LUT
//   LutWe, LutAddr, LutData             target LUT write port
//   InstIn                              instruction for InstAddress (same cycle)
//   InstAddress                         current PC
//   Running, Done                       RUN / HALTED status
//   CycleCount                          saturating count of RUN cycles
module inst_fetch #(
  parameter int unsigned A  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [2:0]    TargetSel,
  input  logic          LutWe,
  input  logic [2:0]    LutAddr,
  input  logic [A-1:0]  LutData,
  input  logic [W-1:0]  InstIn,
  output logic [A-1:0]  InstAddress,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  localparam int unsigned LUT_N = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  state_e          state_q;
  logic [A-1:0]    pc_q;
  logic [CW-1:0]   cyc_q;
  logic            running_q;
  logic            done_q;
  logic [A-1:0]    lut_q [LUT_N];

  logic [A-1:0]    tgt;
  logic [A-1:0]    pc_d;
  logic [CW-1:0]   cyc_d;
  logic            halt;

  // Next PC while running and not stalled; LUT read sees pre-write contents.
  // Relative adds wrap mod 2^A, so high LUT values act as backward offsets.
  always_comb begin
    tgt   = lut_q[TargetSel];
    halt  = &InstIn;
    pc_d  = pc_q + A'(1);
    if (BranchEn) begin
      pc_d = BranchRel ? (pc_q + tgt) : tgt;
    end
    cyc_d = (&cyc_q) ? cyc_q : (cyc_q + CW'(1));
  end

  // Run-control FSM, PC, counter and target LUT.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cyc_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < int'(LUT_N); i++) begin
        lut_q[i] <= A'(i);
      end
    end else begin
      if (LutWe) begin
        lut_q[LutAddr] <= LutData;
      end
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (Start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            pc_q      <= '0;
            cyc_q     <= '0;
          end
        end
        S_RUN: begin
          cyc_q <= cyc_d;
          // Stall masks both halt detection and branching.
          if (!Stall) begin
            if (halt) begin
              state_q   <= S_HALTED;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign Running     = running_q;
  assign Done        = done_q;
  assign CycleCount  = cyc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: driver steps a behavioural model and
// queues expected outputs; a monitor compares them after each clock edge.
module tb_inst_fetch;

  localparam int unsigned A  = 10;
  localparam int unsigned W  = 9;
  localparam int unsigned CW = 16;

  typedef struct {
    int pc;
    bit run;
    bit done;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stall, br_en, br_rel, lut_we;
  logic [2:0]    tsel, lut_addr;
  logic [A-1:0]  lut_data;
  logic [W-1:0]  inst_in;
  logic [A-1:0]  inst_addr;
  logic          running, done;
  logic [CW-1:0] cyc_cnt;

  logic [W-1:0]  rom [1024];
  assign inst_in = rom[inst_addr];

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // model state
  int m_pc, m_cyc;
  bit m_run, m_done;
  int m_lut [8];

  inst_fetch #(.A(A), .W(W), .CW(CW)) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Stall(stall),
    .BranchEn(br_en), .BranchRel(br_rel), .TargetSel(tsel),
    .LutWe(lut_we), .LutAddr(lut_addr), .LutData(lut_data),
    .InstIn(inst_in), .InstAddress(inst_addr), .Running(running),
    .Done(done), .CycleCount(cyc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs at the falling edge and queue the model's
  // view of the outputs after the following rising edge.
  task automatic step(input bit rst, input bit st, input bit stl, input bit be,
                      input bit rel, input int ts, input bit we, input int wa,
                      input int wd);
    exp_t e;
    int   tgt, off;
    @(negedge clk);
    rst_n    = rst;
    start    = st;
    stall    = stl;
    br_en    = be;
    br_rel   = rel;
    tsel     = 3'(ts);
    lut_we   = we;
    lut_addr = 3'(wa);
    lut_data = A'(wd);
    if (!rst) begin
      m_pc = 0; m_cyc = 0; m_run = 0; m_done = 0;
      for (int i = 0; i < 8; i++) m_lut[i] = i;
    end else begin
      tgt = m_lut[ts];
      if (m_run) begin
        if (m_cyc < 65535) m_cyc = m_cyc + 1;
        if (!stl) begin
          if (rom[m_pc] == 9'h1FF) begin
            m_run = 0; m_done = 1;
          end else if (be && rel) begin
            off  = (tgt >= 512) ? tgt - 1024 : tgt;
            m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
          end else if (be) begin
            m_pc = tgt;
          end else begin
            m_pc = (m_pc + 1) % 1024;
          end
        end
      end else if (st) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cyc = 0;
      end
      if (we) m_lut[wa] = wd;
    end
    e.pc = m_pc; e.run = m_run; e.done = m_done; e.cyc = m_cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int target);
    int k = 0;
    while (m_pc != target && k < 2000) begin
      if (!m_run) break;
      idle(1);
      k++;
    end
    n_chk++;
    if (m_pc != target) begin
      n_fail++;
      $display("FAIL run_to: model pc %0d, required %0d", m_pc, target);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk += 4;
        if (int'(inst_addr) != e.pc || $isunknown(inst_addr)) begin
          n_fail++;
          $display("FAIL pc @%0t: got %0d required %0d", $time, inst_addr, e.pc);
        end
        if (running !== e.run) begin
          n_fail++;
          $display("FAIL running @%0t: got %b required %b", $time, running, e.run);
        end
        if (done !== e.done) begin
          n_fail++;
          $display("FAIL done @%0t: got %b required %b", $time, done, e.done);
        end
        if (int'(cyc_cnt) != e.cyc || $isunknown(cyc_cnt)) begin
          n_fail++;
          $display("FAIL cycles @%0t: got %0d required %0d", $time, cyc_cnt, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 0; start = 0; stall = 0; br_en = 0; br_rel = 0;
    tsel = '0; lut_we = 0; lut_addr = '0; lut_data = '0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;

    // Basic run to a halt word at address 5
    rom[5] = 9'h1FF;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(9);
    rom[5] = '0;

    // Absolute branch with default LUT
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    run_to(2);
    step(1, 0, 0, 1, 0, 7, 0, 0, 0);
    idle(2);

    // Relative branches, including same-cycle write to the read entry
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 3, 10'h3FE);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    run_to(6);
    step(1, 0, 0, 1, 1, 3, 0, 0, 0);
    step(1, 0, 0, 1, 1, 3, 1, 3, 1);
    step(1, 0, 0, 1, 1, 3, 0, 0, 0);
    idle(1);

    // Stall, halt masked by stall, halt beats branch, restart
    run_to(4);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 7, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    rom[10] = 9'h1FF;
    run_to(10);
    step(1, 0, 1, 1, 0, 7, 0, 0, 0);
    step(1, 0, 0, 1, 0, 7, 0, 0, 0);
    step(1, 0, 1, 1, 1, 7, 0, 0, 0);
    idle(1);
    rom[10] = '0;
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Wrap from 1023 to 0
    step(1, 0, 0, 0, 0, 0, 1, 1, 1023);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0);
    idle(2);

    // Reset mid-run restores LUT and ignores Start
    step(1, 0, 0, 0, 0, 0, 1, 2, 50);
    run_to(9);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 2, 0, 0, 0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 12; i++) rom[$urandom_range(0, 1023)] = 9'h1FF;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1023)));
    end

    @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Program-counter / fetch-control stage directly upstream of the instruction ROM; drives its A-bit address and consumes the W-bit instruction it returns combinationally in the same cycle.
- Owns the Start/Done run handshake, sequential and branch next-PC selection through an 8-entry writable branch-target LUT (3-bit index to A-bit target), halt detection, and a run-cycle counter.

Parameters:
- A, 10, PC / instruction-address width
- W, 9, instruction width
- CW, 16, cycle-counter width

Ports:
- Clk  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  begin a program run (level sampled each cycle)
- Stall  in  1  hold PC this cycle (downstream not ready)
- BranchEn  in  1  take a branch at end of this cycle
- BranchRel  in  1  1 = PC-relative target, 0 = absolute
- TargetSel  in  3  branch LUT index
- LutWe  in  1  LUT write enable
- LutAddr  in  3  LUT write index
- LutData  in  A  LUT write data
- InstIn  in  W  instruction returned by ROM for InstAddress
- InstAddress  out  A  current PC, to ROM
- Running  out  1  high while in RUN
- Done  out  1  high while in HALTED
- CycleCount  out  CW  cycles spent in RUN for the current/last run

Behaviour:
- Reset (Reset==0 at edge): state IDLE, PC=0, Done=0, Running=0, CycleCount=0, LUT[i]=i for i=0..7. Reset dominates all other inputs, including mid-run.
- All outputs are registered state; InstAddress==PC.
- States: IDLE, RUN, HALTED. Running=(state==RUN), Done=(state==HALTED).
- IDLE: Start=1 -> RUN; PC=0, CycleCount=0.
- RUN, each edge:
  - CycleCount += 1, saturating at all-ones. Increments during stalls.
  - Halt: InstIn=={W{1}} and Stall=0 -> HALTED; PC holds. Halt has priority over BranchEn.
  - Stall=1 -> PC holds; BranchEn and halt are ignored that cycle.
  - BranchEn=1, BranchRel=0 -> PC=LUT[TargetSel].
  - BranchEn=1, BranchRel=1 -> PC=(PC+LUT[TargetSel]) mod 2^A. The LUT value is treated as two's complement, so backward branches use high values.
  - Otherwise PC=PC+1 mod 2^A; PC 2^A-1 wraps to 0.
  - Start is ignored while in RUN.
- HALTED: PC and CycleCount hold. Start=1 -> RUN with PC=0, CycleCount=0. Done deasserts the cycle after Start is sampled.
- Outside RUN, BranchEn, BranchRel, TargetSel and Stall are ignored.
- LUT writes:
  - Accepted in any state when Reset=1.
  - A same-cycle write and branch read of the same entry uses the old value; the new value is visible next cycle.
  - Two writes to the same index: last write wins.
- No combinational path from any input to any output.

Test Plan:
- Reset then Start pulse; ROM returns 0 at all addresses other than 5, where it returns 1_1111_1111 -> InstAddress steps 0,1,2,3,4,5; Done=1 the cycle after PC=5 is presented; PC holds at 5; CycleCount=6.
- Absolute branch: default LUT; at PC=2 drive BranchEn=1, BranchRel=0, TargetSel=7 -> next PC=7, then 8.
- Relative branch: write LUT[3]=10'h3FE; at PC=6 drive BranchEn=1, BranchRel=1, TargetSel=3 -> PC=4. Same-cycle write LUT[3]=1 with branch on index 3 -> PC uses the old value.
- Stall and priority:
  - Stall=1 for 3 cycles at PC=4 -> PC stays 4 and CycleCount still increments.
  - Halt word with Stall=1 -> no halt.
  - Halt word with BranchEn=1 -> HALTED, no branch.
- Wrap and restart:
  - Branch absolute to LUT entry set to 1023, then sequential -> PC=0.
  - After HALTED, Start -> PC=0, CycleCount=0, Running=1.
- Reset mid-run at PC=9 with LUT[2] previously written to 50 -> IDLE, PC=0, Done=0, CycleCount=0, LUT[2]=2; Start is ignored during the reset cycle.
